// File: rtl/percep_pipreg_macnet.sv
// ---------------------------------------------------------------------------------------------
// percep_pipreg_macnet
//
// Pipeline register bank placed between the perceptron fp multipliers and the fp adders.
//
// Product path: NUM_LANE lanes of fp_prod travel through PROD_DEPTH register stages together
// with one valid bit per stage. The priority is rst > flush > stall > advance.
//   - flush   : every stage valid bit clears; data registers hold.
//   - stall   : all stages hold; the beat offered at the input is not captured.
//   - advance : stage0 takes {fp_prod, prod_vld}, stage k takes stage k-1.
// Data registers load on every advance whether or not the beat is valid; only the valid bits
// give the data meaning.
//
// Sum path: one register per lane. A per-lane clr_sum zeroes that lane and wins over stall and
// sum_vld. Otherwise the lane loads fp_sum when sum_vld is high and stall is low. flush does not
// touch the sum path.
//
// inflight is the number of valid product stages, registered alongside the stages. empty is
// inflight == 0, so it is high for the whole time rst is high.
//
// Ports
//   clk           in   clock, all state on posedge
//   rst           in   asynchronous active-high reset
//   stall         in   hold all stages this cycle
//   flush         in   invalidate all product stages
//   clr_sum       in   per-lane zero of fp_sum_pip
//   prod_vld      in   fp_prod carries a valid beat
//   fp_prod       in   lane products, lane i at [i*FP_WIDTH +: FP_WIDTH]
//   sum_vld       in   fp_sum carries a valid beat
//   fp_sum        in   lane partial sums, same packing
//   fp_prod_pip   out  product after PROD_DEPTH stages
//   prod_vld_pip  out  valid of fp_prod_pip
//   fp_sum_pip    out  registered partial sums
//   inflight      out  count of valid product stages
//   empty         out  inflight == 0
// ---------------------------------------------------------------------------------------------
module percep_pipreg_macnet #(
    parameter int unsigned FP_WIDTH   = 16,
    parameter int unsigned NUM_LANE   = 4,
    parameter int unsigned PROD_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic [NUM_LANE-1:0]                   clr_sum,
    input  logic                                  prod_vld,
    input  logic [NUM_LANE*FP_WIDTH-1:0]          fp_prod,
    input  logic                                  sum_vld,
    input  logic [NUM_LANE*FP_WIDTH-1:0]          fp_sum,
    output logic [NUM_LANE*FP_WIDTH-1:0]          fp_prod_pip,
    output logic                                  prod_vld_pip,
    output logic [NUM_LANE*FP_WIDTH-1:0]          fp_sum_pip,
    output logic [$clog2(PROD_DEPTH+1)-1:0]       inflight,
    output logic                                  empty
);

    localparam int unsigned DataW = NUM_LANE * FP_WIDTH;
    localparam int unsigned CntW  = $clog2(PROD_DEPTH + 1);

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [DataW-1:0]      prod_data_q [PROD_DEPTH];
    logic [DataW-1:0]      prod_data_d [PROD_DEPTH];
    logic [PROD_DEPTH-1:0] prod_vld_q;
    logic [PROD_DEPTH-1:0] prod_vld_d;
    logic [CntW-1:0]       inflight_q;
    logic [CntW-1:0]       inflight_d;
    logic [DataW-1:0]      sum_q;
    logic [DataW-1:0]      sum_d;

    // ---------------------------------------------------------------------------------------
    // Product path next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        prod_data_d = prod_data_q;
        prod_vld_d  = prod_vld_q;
        if (flush) begin
            // Data registers keep their contents; only the valid bits are dropped.
            prod_vld_d = '0;
        end else if (!stall) begin
            prod_data_d[0] = fp_prod;
            prod_vld_d[0]  = prod_vld;
            for (int unsigned k = 1; k < PROD_DEPTH; k++) begin
                prod_data_d[k] = prod_data_q[k-1];
                prod_vld_d[k]  = prod_vld_q[k-1];
            end
        end
    end

    // Popcount of the post-update valid bits; bounded by PROD_DEPTH by construction.
    always_comb begin
        inflight_d = '0;
        for (int unsigned k = 0; k < PROD_DEPTH; k++) begin
            inflight_d = inflight_d + CntW'(prod_vld_d[k]);
        end
    end

    // ---------------------------------------------------------------------------------------
    // Sum path next state, lanes independent
    // ---------------------------------------------------------------------------------------
    always_comb begin
        sum_d = sum_q;
        for (int unsigned i = 0; i < NUM_LANE; i++) begin
            if (clr_sum[i]) begin
                sum_d[i*FP_WIDTH +: FP_WIDTH] = '0;
            end else if (!stall && sum_vld) begin
                sum_d[i*FP_WIDTH +: FP_WIDTH] = fp_sum[i*FP_WIDTH +: FP_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < PROD_DEPTH; k++) begin
                prod_data_q[k] <= '0;
            end
            prod_vld_q <= '0;
            inflight_q <= '0;
            sum_q      <= '0;
        end else begin
            for (int unsigned k = 0; k < PROD_DEPTH; k++) begin
                prod_data_q[k] <= prod_data_d[k];
            end
            prod_vld_q <= prod_vld_d;
            inflight_q <= inflight_d;
            sum_q      <= sum_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign fp_prod_pip  = prod_data_q[PROD_DEPTH-1];
    assign prod_vld_pip = prod_vld_q[PROD_DEPTH-1];
    assign fp_sum_pip   = sum_q;
    assign inflight     = inflight_q;
    assign empty        = (inflight_q == '0);

endmodule

// File: tb/tb_percep_pipreg_macnet.sv
// ---------------------------------------------------------------------------------------------
// tb_percep_pipreg_macnet
//
// Scoreboard bench. Every beat accepted into the product path is pushed with the advance count
// at which it entered; a beat is due at the output once PROD_DEPTH further advances have
// happened, and leaves the queue on the advance after that. flush and rst empty the queue.
// The queue length is the expected inflight. The sum path has its own per-lane expectation.
// Outputs are checked every falling edge; inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------------------------
module tb_percep_pipreg_macnet;

    localparam int unsigned FP_WIDTH   = 16;
    localparam int unsigned NUM_LANE   = 4;
    localparam int unsigned PROD_DEPTH = 2;
    localparam int unsigned DW         = FP_WIDTH * NUM_LANE;
    localparam int unsigned CW         = $clog2(PROD_DEPTH + 1);

    logic                clk;
    logic                rst;
    logic                stall;
    logic                flush;
    logic [NUM_LANE-1:0] clr_sum;
    logic                prod_vld;
    logic [DW-1:0]       fp_prod;
    logic                sum_vld;
    logic [DW-1:0]       fp_sum;
    logic [DW-1:0]       fp_prod_pip;
    logic                prod_vld_pip;
    logic [DW-1:0]       fp_sum_pip;
    logic [CW-1:0]       inflight;
    logic                empty;

    percep_pipreg_macnet #(
        .FP_WIDTH   (FP_WIDTH),
        .NUM_LANE   (NUM_LANE),
        .PROD_DEPTH (PROD_DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .clr_sum      (clr_sum),
        .prod_vld     (prod_vld),
        .fp_prod      (fp_prod),
        .sum_vld      (sum_vld),
        .fp_sum       (fp_sum),
        .fp_prod_pip  (fp_prod_pip),
        .prod_vld_pip (prod_vld_pip),
        .fp_sum_pip   (fp_sum_pip),
        .inflight     (inflight),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   e;
    } beat_t;

    beat_t         sb[$];
    int unsigned   adv_cnt = 0;
    logic [DW-1:0] sum_exp = '0;

    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            sum_exp <= '0;
        end else begin
            if (flush) begin
                sb.delete();
            end else if (!stall) begin
                if (sb.size() > 0 && adv_cnt - sb[0].e == PROD_DEPTH) begin
                    void'(sb.pop_front());
                end
                if (prod_vld) sb.push_back('{d: fp_prod, e: adv_cnt});
                adv_cnt <= adv_cnt + 1;
            end
            for (int i = 0; i < NUM_LANE; i++) begin
                if (clr_sum[i]) sum_exp[i*FP_WIDTH +: FP_WIDTH] <= '0;
                else if (!stall && sum_vld)
                    sum_exp[i*FP_WIDTH +: FP_WIDTH] <= fp_sum[i*FP_WIDTH +: FP_WIDTH];
            end
        end
    end

    bit chk_en = 1'b1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                check("rst_prod_vld_pip", DW'(prod_vld_pip), '0);
                check("rst_fp_prod_pip", fp_prod_pip, '0);
                check("rst_fp_sum_pip", fp_sum_pip, '0);
                check("rst_inflight", DW'(inflight), '0);
                check("rst_empty", DW'(empty), DW'(1));
            end else begin
                automatic logic exp_v = (sb.size() > 0) && (adv_cnt - sb[0].e == PROD_DEPTH);
                check("prod_vld_pip", DW'(prod_vld_pip), DW'(exp_v));
                if (exp_v) check("fp_prod_pip", fp_prod_pip, sb[0].d);
                check("inflight", DW'(inflight), DW'(sb.size()));
                check("empty", DW'(empty), DW'(sb.size() == 0));
                check("fp_sum_pip", fp_sum_pip, sum_exp);
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall    = 1'b0;
        flush    = 1'b0;
        clr_sum  = '0;
        prod_vld = 1'b0;
        sum_vld  = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [DW-1:0] hold_sum;
        rst     = 1'b1;
        fp_prod = '0;
        fp_sum  = '0;
        idle();

        // T1: reset with random inputs
        for (int c = 0; c < 4; c++) begin
            stall    = 1'($urandom);
            flush    = 1'($urandom);
            clr_sum  = 4'($urandom);
            prod_vld = 1'($urandom);
            sum_vld  = 1'($urandom);
            fp_prod  = rnd64();
            fp_sum   = rnd64();
            tick();
        end
        idle();
        fp_prod = '0;
        fp_sum  = '0;
        rst     = 1'b0;
        tick();
        tick();
        #4;
        check("t1_prod_zero", fp_prod_pip, '0);
        check("t1_empty", DW'(empty), DW'(1));

        // T2: two-beat pulse, lane0 = 3C00 first; inflight 1,2,1,0
        @(posedge clk); #1;
        prod_vld = 1'b1;
        fp_prod  = DW'(16'h3C00);
        tick();
        fp_prod  = DW'(16'h4400);
        #3 check("t2_inflight1", DW'(inflight), DW'(1));
        tick();
        idle();
        fp_prod = '0;
        #3 check("t2_inflight2", DW'(inflight), DW'(2));
        check("t2_vld_at_lat", DW'(prod_vld_pip), DW'(1));
        check("t2_lane0", DW'(fp_prod_pip[FP_WIDTH-1:0]), DW'(16'h3C00));
        tick();
        #3 check("t2_inflight3", DW'(inflight), DW'(1));
        tick();
        #3 check("t2_inflight4", DW'(inflight), DW'(0));
        tick();

        // T3: A, B, stall 3 cycles offering D, then C
        prod_vld = 1'b1;
        fp_prod  = 64'hAAAA_0001_AAAA_0001;
        tick();
        fp_prod  = 64'hBBBB_0002_BBBB_0002;
        tick();
        stall    = 1'b1;
        fp_prod  = 64'hDDDD_0004_DDDD_0004;
        for (int c = 0; c < 3; c++) tick();
        stall    = 1'b0;
        fp_prod  = 64'hCCCC_0003_CCCC_0003;
        tick();
        idle();
        for (int c = 0; c < 4; c++) tick();

        // T4: two beats in, then flush together with a third
        prod_vld = 1'b1;
        fp_prod  = rnd64();
        tick();
        fp_prod  = rnd64();
        tick();
        flush    = 1'b1;
        fp_prod  = rnd64();
        tick();
        idle();
        #3 check("t4_inflight0", DW'(inflight), '0);
        check("t4_empty", DW'(empty), DW'(1));
        for (int c = 0; c < 3; c++) tick();

        // T5: load sums, then clear lane1 under stall with sum_vld
        sum_vld = 1'b1;
        fp_sum  = 64'h1111_2222_4000_3333;
        tick();
        hold_sum = fp_sum;
        clr_sum  = 4'b0010;
        stall    = 1'b1;
        fp_sum   = 64'h9999_8888_7777_6666;
        tick();
        idle();
        #3 check("t5_sum", fp_sum_pip, hold_sum & ~64'h0000_0000_FFFF_0000);
        tick();

        // T6: 20 back-to-back beats
        prod_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            fp_prod = rnd64();
            sum_vld = 1'($urandom);
            fp_sum  = rnd64();
            tick();
        end
        idle();
        #3 check("t6_sat", DW'(inflight), DW'(PROD_DEPTH));
        for (int c = 0; c < 4; c++) tick();

        // Random mix of stall/flush/clr_sum
        for (int c = 0; c < 200; c++) begin
            prod_vld = 1'($urandom);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            clr_sum  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            sum_vld  = 1'($urandom);
            fp_prod  = rnd64();
            fp_sum   = rnd64();
            tick();
        end

        // Reset mid-operation is immediate
        prod_vld = 1'b1;
        fp_prod  = rnd64();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async_empty", DW'(empty), DW'(1));
        check("async_inflight", DW'(inflight), '0);
        check("async_vld", DW'(prod_vld_pip), '0);
        tick();
        idle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
